// File: rtl/biu_fetch_responder.sv
// Purpose: responder-side bus interface unit; turns each FCU/datapath request into one external memory cycle.
// Latency: ready_biu low from the accepting edge until the edge that samples mem_ack (1 cycle min, TIMEOUT max).
// Backpressure: ready_biu=0 while busy; requests are never queued and input changes during ACCESS are ignored.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   cs_biu, sel_biu     - request select (only logic 1 counts) and kind: 11 fetch, 01 data read, 10 data write
//   fetch_address       - request word address; wr_data - write data for sel_biu=10
//   bus, ready_biu      - registered read data and idle/complete flag back to the requester
//   biu_err             - sticky timeout flag, cleared by the next accepted request
//   mem_addr, mem_rd, mem_wr, mem_wdata - registered external memory request
//   mem_rdata, mem_ack  - external read data and completion handshake
module biu_fetch_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_biu,
  input  logic [1:0]        sel_biu,
  input  logic [ADDR_W-1:0] fetch_address,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] bus,
  output logic              ready_biu,
  output logic              biu_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  // Counter value seen during the last ACCESS cycle before giving up.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [1:0]          last_sel_q, last_sel_d;
  logic                have_last_q, have_last_d;
  logic [3:0]          cnt_q, cnt_d;

  logic cs_on;
  logic req_vld;
  logic req_new;
  logic accept;

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    ready_d     = ready_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    last_addr_d = last_addr_q;
    last_sel_d  = last_sel_q;
    have_last_d = have_last_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;

    // An X/Z select falls through to the else branch, so it never counts as asserted.
    cs_on = 1'b0;
    if (cs_biu == 1'b1) cs_on = 1'b1;
    req_vld = cs_on && (sel_biu != 2'b00);
    // A requester parked on the same address/kind after completion must not be serviced again.
    // Without a completed transfer on record (timeout straight from IDLE) the held request is retried.
    req_new = (fetch_address != last_addr_q) || (sel_biu != last_sel_q) || !have_last_q;

    case (state_q)
      IDLE: begin
        if (req_vld) accept = 1'b1;
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (mem_ack) begin
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b0;
          if (mem_rd_q) bus_d = mem_rdata;
          ready_d     = 1'b1;
          have_last_d = 1'b1;
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          bus_d    = '1;
          err_d    = 1'b1;
          ready_d  = 1'b1;
          state_d  = ERR;
        end
      end
      DONE, ERR: begin
        if (!cs_on) begin
          have_last_d = 1'b0;
          state_d     = IDLE;
        end else if (req_vld && req_new) begin
          accept = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      mem_addr_d  = fetch_address;
      last_addr_d = fetch_address;
      last_sel_d  = sel_biu;
      mem_wdata_d = wr_data;
      ready_d     = 1'b0;
      err_d       = 1'b0;
      cnt_d       = 4'd0;
      mem_rd_d    = sel_biu[0];
      mem_wr_d    = (sel_biu == 2'b10);
      state_d     = ACCESS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_q       <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      last_addr_q <= '0;
      last_sel_q  <= 2'b00;
      have_last_q <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      last_addr_q <= last_addr_d;
      last_sel_q  <= last_sel_d;
      have_last_q <= have_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus       = bus_q;
  assign ready_biu = ready_q;
  assign biu_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
